// File: rtl/cnt_pkg.sv
// Shared types and helpers for the modulo up/down counter.
package cnt_pkg;

    // Counter run state: RUN counts, HALT freezes after a one-shot completes.
    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Terminal value for a direction: MOD-1 counting up, 0 counting down.
    function automatic int unsigned tv(input logic dir, input int unsigned mod);
        return (dir == DIR_UP) ? mod - 1 : 0;
    endfunction

endpackage

// File: rtl/cnt_next_val.sv
// Combinational next-value logic for the modulo up/down counter.
// Produces the clamped load value or the modulo step, and flags q == terminal value.
module cnt_next_val
    import cnt_pkg::*;
#(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned MOD   = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] next_val,
    output logic             at_tv
);

    // Largest legal count; comparing against it avoids forming MOD itself,
    // which does not fit in WIDTH bits when MOD == 2**WIDTH.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] tv_val;

    assign tv_val = WIDTH'(tv(up_dn, MOD));

    // Select clamped load value, else the wrap-aware step in the current direction.
    always_comb begin
        next_val = q;
        if (load) begin
            next_val = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (up_dn == DIR_UP) begin
            next_val = (q == MAX_VAL) ? '0 : q + WIDTH'(1);
        end else begin
            next_val = (q == '0) ? MAX_VAL : q - WIDTH'(1);
        end
    end

    // Terminal value follows the live direction input, so a direction change is seen at once.
    always_comb begin
        at_tv = (q == tv_val);
    end

endmodule

// File: rtl/sync_mod_updown_counter.sv
// Synchronous modulo-N up/down counter with parallel load, count enable,
// terminal-count strobe, wrap pulse and an optional one-shot (stop at terminal) mode.
module sync_mod_updown_counter
    import cnt_pkg::*;
#(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned MOD   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             oneshot,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             done
);

    state_e           state;
    logic [WIDTH-1:0] next_val;
    logic             at_tv;

    cnt_next_val #(
        .WIDTH (WIDTH),
        .MOD   (MOD)
    ) u_next_val (
        .q        (q),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .next_val (next_val),
        .at_tv    (at_tv)
    );

    // Terminal count decoded straight from the registered count: no added latency.
    always_comb begin
        tc = en & (state == RUN) & at_tv;
    end

    // Count register, wrap/done flags and RUN/HALT state; load overrides everything but reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q     <= '0;
            wrap  <= 1'b0;
            done  <= 1'b0;
            state <= RUN;
        end else if (load) begin
            q     <= next_val;
            wrap  <= 1'b0;
            done  <= 1'b0;
            state <= RUN;
        end else begin
            case (state)
                HALT: begin
                    // Frozen; leaving one-shot mode resumes counting but keeps done set.
                    wrap <= 1'b0;
                    if (!oneshot) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (en) begin
                        if (oneshot && at_tv) begin
                            state <= HALT;
                            done  <= 1'b1;
                            wrap  <= 1'b0;
                        end else begin
                            q    <= next_val;
                            wrap <= at_tv;
                        end
                    end else begin
                        wrap <= 1'b0;
                    end
                end
                default: begin
                    state <= RUN;
                    wrap  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_mod_updown_counter.sv
// Bench for sync_mod_updown_counter: two instances (MOD=8 full range, MOD=6 partial),
// directed scenarios with literal expectations, then randomized stimulus against a model.
module tb_sync_mod_updown_counter;

    localparam int MODS [2] = '{8, 6};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  [2];
    logic       ud  [2];
    logic       ld  [2];
    logic       os  [2];
    logic [2:0] lv  [2];
    logic [2:0] q   [2];
    logic       tc  [2];
    logic       wr  [2];
    logic       dn  [2];

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    // Behavioural model state: count value, wrap pulse, done flag, halted flag.
    int mq [2] = '{0, 0};
    bit mw [2] = '{0, 0};
    bit md [2] = '{0, 0};
    bit mh [2] = '{0, 0};

    sync_mod_updown_counter #(.WIDTH(3), .MOD(8)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .en       (en[0]),
        .up_dn    (ud[0]),
        .load     (ld[0]),
        .load_val (lv[0]),
        .oneshot  (os[0]),
        .q        (q[0]),
        .tc       (tc[0]),
        .wrap     (wr[0]),
        .done     (dn[0])
    );

    sync_mod_updown_counter #(.WIDTH(3), .MOD(6)) dut6 (
        .clk      (clk),
        .rst      (rst),
        .en       (en[1]),
        .up_dn    (ud[1]),
        .load     (ld[1]),
        .load_val (lv[1]),
        .oneshot  (os[1]),
        .q        (q[1]),
        .tc       (tc[1]),
        .wrap     (wr[1]),
        .done     (dn[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Inputs change 2 time units after a posedge and stay stable until the next one.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference model: modulo arithmetic straight from the counting rules.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mq[i] <= 0;
                mw[i] <= 1'b0;
                md[i] <= 1'b0;
                mh[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                int m;
                int term;
                int nq;
                bit nw;
                bit nd;
                bit nh;
                m    = MODS[i];
                term = ud[i] ? m - 1 : 0;
                nq   = mq[i];
                nw   = 1'b0;
                nd   = md[i];
                nh   = mh[i];
                if (ld[i]) begin
                    nq = (int'(lv[i]) >= m) ? m - 1 : int'(lv[i]);
                    nd = 1'b0;
                    nh = 1'b0;
                end else if (mh[i]) begin
                    if (!os[i]) nh = 1'b0;
                end else if (en[i]) begin
                    if (os[i] && mq[i] == term) begin
                        nh = 1'b1;
                        nd = 1'b1;
                    end else begin
                        nq = ud[i] ? (mq[i] + 1) % m : (mq[i] + m - 1) % m;
                        nw = (mq[i] == term);
                    end
                end
                mq[i] <= nq;
                mw[i] <= nw;
                md[i] <= nd;
                mh[i] <= nh;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                bit exp_tc;
                exp_tc = en[i] && !mh[i] && (mq[i] == (ud[i] ? MODS[i] - 1 : 0));
                check($sformatf("model_q[%0d]", i), 32'(q[i]), 32'(mq[i]));
                check($sformatf("model_wrap[%0d]", i), 32'(wr[i]), 32'(mw[i]));
                check($sformatf("model_done[%0d]", i), 32'(dn[i]), 32'(md[i]));
                check($sformatf("model_tc[%0d]", i), 32'(tc[i]), 32'(exp_tc));
                check($sformatf("range_q[%0d]", i), 32'(int'(q[i]) < MODS[i]), 32'd1);
                assert (int'(q[i]) < MODS[i]);
            end
        end
    end

    initial begin
        int nwraps;
        for (int i = 0; i < 2; i++) begin
            en[i] = 1'b0;
            ud[i] = 1'b1;
            ld[i] = 1'b0;
            os[i] = 1'b0;
            lv[i] = 3'd0;
        end

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_q8", 32'(q[0]), 0);
        check("rst_wrap8", 32'(wr[0]), 0);
        check("rst_done8", 32'(dn[0]), 0);
        check("rst_q6", 32'(q[1]), 0);
        tick();
        rst    = 1'b0;
        chk_on = 1'b1;

        // 1. Reset mid-count, MOD=8
        ld[0] = 1'b1; lv[0] = 3'd0;
        tick();
        ld[0] = 1'b0; en[0] = 1'b1; ud[0] = 1'b1;
        repeat (5) tick();
        check("t1_q_before_rst", 32'(q[0]), 5);
        rst = 1'b1;
        #1;
        check("t1_q_async", 32'(q[0]), 0);
        check("t1_wrap_async", 32'(wr[0]), 0);
        check("t1_done_async", 32'(dn[0]), 0);
        rst = 1'b0;
        tick();
        check("t1_q_after_release", 32'(q[0]), 1);
        en[0] = 1'b0;

        // 2. Up wrap, MOD=6
        ld[1] = 1'b1; lv[1] = 3'd0; ud[1] = 1'b1;
        tick();
        check("t2_q_start", 32'(q[1]), 0);
        ld[1] = 1'b0; en[1] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("t2_q_seq", 32'(q[1]), 32'(k % 6));
            check("t2_tc", 32'(tc[1]), 32'(k == 5));
            check("t2_wrap", 32'(wr[1]), 32'(k == 6));
        end
        tick();
        check("t2_wrap_one_cycle", 32'(wr[1]), 0);
        en[1] = 1'b0;

        // 3. Down wrap then direction change, MOD=6
        ld[1] = 1'b1; lv[1] = 3'd2; ud[1] = 1'b0;
        tick();
        check("t3_q_load", 32'(q[1]), 2);
        ld[1] = 1'b0; en[1] = 1'b1;
        tick(); check("t3_q_1", 32'(q[1]), 1);
        tick(); check("t3_q_0", 32'(q[1]), 0);
        check("t3_tc_at_0", 32'(tc[1]), 1);
        tick(); check("t3_q_5", 32'(q[1]), 5);
        check("t3_wrap", 32'(wr[1]), 1);
        tick(); check("t3_q_4", 32'(q[1]), 4);
        ud[1] = 1'b1;
        #1 check("t3_tc_up_at_4", 32'(tc[1]), 0);
        tick(); check("t3_q_up_5", 32'(q[1]), 5);
        check("t3_tc_up_at_5", 32'(tc[1]), 1);
        en[1] = 1'b0;

        // 4. One-shot, MOD=8
        os[0] = 1'b1; ud[0] = 1'b1; ld[0] = 1'b1; lv[0] = 3'd6;
        tick();
        check("t4_q_6", 32'(q[0]), 6);
        ld[0] = 1'b0; en[0] = 1'b1;
        #1 check("t4_tc_at_6", 32'(tc[0]), 0);
        tick(); check("t4_q_7", 32'(q[0]), 7);
        check("t4_tc_at_7", 32'(tc[0]), 1);
        check("t4_done_pre", 32'(dn[0]), 0);
        tick(); check("t4_q_hold", 32'(q[0]), 7);
        check("t4_done", 32'(dn[0]), 1);
        check("t4_tc_halt", 32'(tc[0]), 0);
        check("t4_no_wrap", 32'(wr[0]), 0);
        en[0] = 1'b0;
        tick(); check("t4_q_hold_en0", 32'(q[0]), 7);
        en[0] = 1'b1;
        tick(); check("t4_q_hold_en1", 32'(q[0]), 7);
        ud[0] = 1'b0;
        tick(); check("t4_q_hold_dn", 32'(q[0]), 7);
        ud[0] = 1'b1; os[0] = 1'b0;
        tick(); check("t4_q_exit_halt", 32'(q[0]), 7);
        check("t4_done_sticky", 32'(dn[0]), 1);
        tick(); check("t4_q_resume_wrap", 32'(q[0]), 0);
        check("t4_wrap_after_resume", 32'(wr[0]), 1);
        check("t4_done_still", 32'(dn[0]), 1);
        os[0] = 1'b1; ld[0] = 1'b1; lv[0] = 3'd3;
        tick(); check("t4_q_load3", 32'(q[0]), 3);
        check("t4_done_cleared", 32'(dn[0]), 0);
        ld[0] = 1'b0;
        tick(); check("t4_q_resume", 32'(q[0]), 4);
        en[0] = 1'b0; os[0] = 1'b0;

        // 5. Load clamp and load-over-count priority, MOD=6
        ld[1] = 1'b1; lv[1] = 3'd7; en[1] = 1'b0;
        tick(); check("t5_clamp", 32'(q[1]), 5);
        ld[1] = 1'b0; en[1] = 1'b1; ud[1] = 1'b1;
        #1 check("t5_tc", 32'(tc[1]), 1);
        ld[1] = 1'b1; lv[1] = 3'd2;
        tick(); check("t5_load_wins", 32'(q[1]), 2);
        check("t5_no_wrap", 32'(wr[1]), 0);
        ld[1] = 1'b0; en[1] = 1'b0;

        // 6. Full modulus, MOD=8
        ld[0] = 1'b1; lv[0] = 3'd0; ud[0] = 1'b1;
        tick();
        ld[0] = 1'b0; en[0] = 1'b1;
        nwraps = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (wr[0]) nwraps++;
            check("t6_q", 32'(q[0]), 32'(k % 8));
        end
        check("t6_wrap_count", 32'(nwraps), 2);

        // Randomized phase against the model
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 2; i++) begin
                ld[i] = ($urandom_range(0, 11) == 0);
                lv[i] = 3'($urandom_range(0, 7));
                en[i] = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) == 0) ud[i] = ~ud[i];
                if ($urandom_range(0, 15) == 0) os[i] = ~os[i];
            end
            if (c == 300) begin
                rst = 1'b1;
                #1 rst = 1'b0;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
